// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused and falls back to IDLE in the FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/halfadder.sv
// rtl/halfadder.sv - one-bit half adder
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum and carry of two bits.
  always_comb begin
    s = a ^ b;
    c = a & b;
  end

endmodule

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - full-adder cell built from two half adders and an OR
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic carry1;
  logic carry2;

  halfadder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (carry1)
  );

  halfadder u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (carry2)
  );

  // The two half-adder carries can never both be set, so OR merges them.
  always_comb begin
    cout = carry1 | carry2;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller with start/busy/done handshake
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Derived from WIDTH and kept local so it cannot drift from it.
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             c_reg;
  logic             s_bit;
  logic             c_out;
  logic             load;
  logic             shift;
  logic             finish;

  // One shared full-adder cell fed from the operand LSBs and the carry loop.
  serial_fa_cell u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (c_reg),
    .s    (s_bit),
    .cout (c_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = IDLE;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt == LAST_BIT) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, bit counter, carry loop and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      c_reg  <= 1'b0;
      sum    <= '0;
      carry  <= 1'b0;
    end else if (load) begin
      sh_a   <= a;
      sh_b   <= b;
      res_sh <= '0;
      cnt    <= '0;
      c_reg  <= 1'b0;
    end else if (shift) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      res_sh <= {s_bit, res_sh[WIDTH-1:1]};
      c_reg  <= c_out;
      // Counter stops at the last bit; leaving RUN makes a wrap unreachable.
      if (!finish) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        sum   <= {s_bit, res_sh[WIDTH-1:1]};
        carry <= c_out;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;

  int checks;
  int errors;
  logic [7:0] last_sum;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[9];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One operation from a negedge; optionally scrambles a/b every cycle after capture.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] es, input logic ec, input bit scramble);
    int nbusy;
    int ndone;
    int didx;
    bit held;
    logic [7:0] got_s;
    logic       got_c;
    nbusy = 0; ndone = 0; didx = 0; held = 1'b1; got_s = '0; got_c = 1'b0;
    a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (scramble) begin
        a = 8'hFF;
        b = 8'hFF;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        didx  = cyc;
        got_s = sum;
        got_c = carry;
      end else if (busy && ndone == 0 && sum !== last_sum) begin
        held = 1'b0;
      end
      if (!busy) break;
    end
    check("busy_cycles", 32'(nbusy), 32'd9);
    check("done_pulses", 32'(ndone), 32'd1);
    check("done_cycle", 32'(didx), 32'd9);
    check("sum_held", 32'(held), 32'd1);
    check("sum", 32'(got_s), 32'(es));
    check("carry", 32'(got_c), 32'(ec));
    last_sum = es;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_sum = 8'h00;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
    vecs[1] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'h7F, s: 8'hFE, c: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
    vecs[5] = '{a: 8'h55, b: 8'hAA, s: 8'hFF, c: 1'b0};
    vecs[6] = '{a: 8'hC8, b: 8'h64, s: 8'h2C, c: 1'b1};
    vecs[7] = '{a: 8'h01, b: 8'h01, s: 8'h02, c: 1'b0};
    vecs[8] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_sum", 32'(sum), 32'd0);
      check("idle_carry", 32'(carry), 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 1'b0);
    end

    // start held high: done every 10 cycles, one IDLE cycle between operations.
    begin
      int ndone;
      bit pos_ok;
      ndone = 0;
      pos_ok = 1'b1;
      a = 8'h03; b = 8'h04; start = 1'b1;
      for (int i = 0; i < 30; i++) begin
        if (i > 0) @(negedge clk);
        if (done) begin
          ndone++;
          if (!(i == 9 || i == 19 || i == 29)) pos_ok = 1'b0;
          check("hold_sum", 32'(sum), 32'h07);
        end else if (i == 9 || i == 19 || i == 29) begin
          pos_ok = 1'b0;
        end
      end
      start = 1'b0;
      check("hold_done_pulses", 32'(ndone), 32'd3);
      check("hold_done_cycles", 32'(pos_ok), 32'd1);
      @(negedge clk);
      check("hold_back_idle", 32'(busy), 32'd0);
      last_sum = 8'h07;
    end

    @(negedge clk);
    run_op(8'h0F, 8'h01, 8'h10, 1'b0, 1'b1);

    // Asynchronous reset in the 4th RUN cycle aborts without a done pulse.
    begin
      bit saw_done;
      saw_done = 1'b0;
      a = 8'h7F; b = 8'h7F; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
        if (i == 2) rst_n = 1'b1;
      end
      check("rst_no_done", 32'(saw_done), 32'd0);
      check("rst_after_busy", 32'(busy), 32'd0);
      last_sum = 8'h00;
      run_op(8'h7F, 8'h7F, 8'hFE, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
